psram_arbiter: RTL and testbench
================================

# psram_arbiter

Two-port arbiter that shares the single-beat PSRAM controller (`psram`, 24-bit address, 16-bit data, `i_stb`/`psram_busy`/`o_done` handshake) between two requesters, for example the CPU and a video/DMA engine.

- Captures one command per grant and holds it stable for the whole PSRAM transaction.
- Issues a single strobe per command.
- Routes completion and read data back to the owning port.
- Sits directly between the requesters and `psram`, in the same `i_clk`/`arst_n` domain.

## Interface

Parameters:
- `PRIO_MODE`, default 0: 0 = round-robin, 1 = fixed priority (port 0 always wins ties).

Ports:
- `i_clk`  in  1  clock. `arst_n`  in  1  reset, asynchronous, active-low.
- `i_p0_req`, `i_p1_req`  in  1  request level. Held high until ack.
- `i_p0_we`, `i_p1_we`  in  1  1 = write, 0 = read. Stable while req is high.
- `i_p0_addr`, `i_p1_addr`  in  24  word address. Stable while req is high.
- `i_p0_din`, `i_p1_din`  in  16  write data. Stable while req is high.
- `o_p0_ack`, `o_p1_ack`  out  1  one-cycle completion pulse.
- `o_p0_rdata`, `o_p1_rdata`  out  16  read data. Valid on the ack cycle of a read; held until that port's next read completes.
- `o_owner`  out  1  index of the port granted last.
- `o_active`  out  1  a transaction is in flight (state ≠ IDLE).
- `o_m_stb`  out  1  to `psram.i_stb`.
- `o_m_we`  out  1  to `psram.i_we`.
- `o_m_addr`  out  24  to `psram.i_addr`.
- `o_m_din`  out  16  to `psram.i_din`.
- `i_m_busy`  in  1  from `psram.psram_busy`.
- `i_m_done`  in  1  from `psram.o_done`.
- `i_m_dout`  in  16  from `psram.o_dout`.

## Operation

- Controller ready = `i_m_done && !i_m_busy`.
  - This condition is false from reset through PSRAM QPI-mode entry.
  - No grant is issued before it becomes true.
- States:
  - **IDLE**: if ready and any req is high, select the winner, latch its we/addr/din into `o_m_*`, set `o_m_stb`=1, set `o_owner`, go to ISSUE. Otherwise stay in IDLE.
  - **ISSUE**: hold `o_m_stb`=1 until `i_m_busy`=1. Then clear `o_m_stb` and go to WAIT.
  - **WAIT**: hold `o_m_*` stable. When `i_m_busy`=0 and `i_m_done`=1:
    - set the owner's ack to 1;
    - if it is a read, capture `i_m_dout` into the owner's rdata;
    - go to ACK.
  - **ACK**: ack is high for exactly this cycle. Clear it and go to IDLE.
- Selection:
  - Only one req high: that port wins.
  - Both high, `PRIO_MODE`=1: port 0 wins.
  - Both high, `PRIO_MODE`=0: the port that is not `o_owner` wins.
- Requester rule: deassert req on the edge that samples ack=1, or keep it high to request the next transaction. IDLE samples req one cycle after ACK, so a single request is never issued twice.
- A req that drops before grant is simply not served. A req that drops after grant does not abort; the ack still pulses.
- A port's rdata is not modified by the other port's reads or by any write.
- `arst_n` low at any time, including mid-transaction: all state and outputs go to reset values immediately. No ack is issued for an aborted command, and the arbiter re-waits for ready.

## Timing

- Reset values:
  - `o_m_stb`=0, `o_m_we`=0, `o_m_addr`=0, `o_m_din`=0;
  - both acks=0, both rdata=0;
  - `o_owner`=1 (so port 0 wins the first round-robin tie);
  - `o_active`=0; state = IDLE.
- Cycle of the req-sampling edge: req high, ready, IDLE. `o_m_stb`=1 and `o_m_*` are valid on the cycle after that edge.
- `o_m_stb` stays high until the cycle after the first `i_m_busy`=1 is sampled. With `psram` this is a 2-cycle strobe.
- `o_m_*` is stable from the grant through the ACK cycle.
- Ack goes high 1 cycle after `busy`=0 and `done`=1 is sampled in WAIT.
- Minimum gap between consecutive grants: 1 IDLE cycle after ACK.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan

1. **Init gate.** Hold `i_m_busy`=1 and `i_m_done`=0 for 100 cycles with p0_req high, then make the controller ready. Required: `o_m_stb`=0 throughout the hold; `o_m_stb`=1 one cycle after ready is sampled.
2. **Single read.** p0 reads addr 0x123456; the model returns 0xBEEF. Required: `o_m_addr`=0x123456 and `o_m_we`=0; one p0_ack pulse; `o_p0_rdata`=0xBEEF; `o_p1_rdata` still 0.
3. **Round-robin.** Both req high, 4 transactions each, `PRIO_MODE`=0. Required: grants in the order p0,p1,p0,p1,…; exactly one strobe per transaction.
4. **Fixed priority.** Same stimulus as scenario 3 with `PRIO_MODE`=1. Required: all 4 p0 transactions complete before the first p1 grant.
5. **Write routing / back-to-back.**
   - p1 writes 0xA5A5 to 0x000010, then immediately reads 0x000010; the model returns 0xA5A5.
   - Required: `o_m_din`=0xA5A5 during the write; two p1_ack pulses; `o_p1_rdata`=0xA5A5; no third strobe.
6. **Reset mid-WAIT.** Pull `arst_n` low during WAIT of a p0 read. Required: all outputs return to reset values within the same cycle; no p0_ack; a new request after release is served once ready.

Source files
------------

// File: rtl/psram_arbiter.sv
// psram_arbiter
//   Shares one single-beat PSRAM controller between two requesters.
//   One command is captured per grant, held stable on o_m_* until the
//   transaction is acknowledged, and completion/read data are routed back
//   to the port that owned the grant.
//
// Ports
//   i_clk, arst_n              clock, asynchronous active-low reset
//   i_pN_req/we/addr/din       requester N command (level request, held until ack)
//   o_pN_ack                   one-cycle completion pulse for port N
//   o_pN_rdata                 last read data returned to port N
//   o_owner                    index of the port granted last
//   o_active                   a transaction is in flight
//   o_m_stb/we/addr/din        command towards the PSRAM controller
//   i_m_busy/done/dout         status and read data from the PSRAM controller
module psram_arbiter #(
  parameter int PRIO_MODE = 0
) (
  input  logic        i_clk,
  input  logic        arst_n,
  input  logic        i_p0_req,
  input  logic        i_p1_req,
  input  logic        i_p0_we,
  input  logic        i_p1_we,
  input  logic [23:0] i_p0_addr,
  input  logic [23:0] i_p1_addr,
  input  logic [15:0] i_p0_din,
  input  logic [15:0] i_p1_din,
  output logic        o_p0_ack,
  output logic        o_p1_ack,
  output logic [15:0] o_p0_rdata,
  output logic [15:0] o_p1_rdata,
  output logic        o_owner,
  output logic        o_active,
  output logic        o_m_stb,
  output logic        o_m_we,
  output logic [23:0] o_m_addr,
  output logic [15:0] o_m_din,
  input  logic        i_m_busy,
  input  logic        i_m_done,
  input  logic [15:0] i_m_dout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t      state_r;
  logic        stb_r;
  logic        we_r;
  logic [23:0] addr_r;
  logic [15:0] din_r;
  logic        owner_r;
  logic        active_r;
  logic        ack0_r;
  logic        ack1_r;
  logic [15:0] rdata0_r;
  logic [15:0] rdata1_r;

  logic        ready_s;
  logic        any_req_s;
  logic        sel_p1_s;

  // Controller readiness and the winner of the next grant.
  always_comb begin
    ready_s   = i_m_done && !i_m_busy;
    any_req_s = i_p0_req || i_p1_req;
    if (PRIO_MODE == 1) begin
      sel_p1_s = i_p1_req && !i_p0_req;
    end else begin
      // Round-robin tie goes to the port that did not win last time.
      sel_p1_s = i_p1_req && (!i_p0_req || !owner_r);
    end
  end

  // Grant/issue/wait/ack sequencer with all outputs registered.
  always_ff @(posedge i_clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r  <= ST_IDLE;
      stb_r    <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= 24'h000000;
      din_r    <= 16'h0000;
      owner_r  <= 1'b1;
      active_r <= 1'b0;
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      rdata0_r <= 16'h0000;
      rdata1_r <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ready_s && any_req_s) begin
            owner_r  <= sel_p1_s;
            we_r     <= sel_p1_s ? i_p1_we   : i_p0_we;
            addr_r   <= sel_p1_s ? i_p1_addr : i_p0_addr;
            din_r    <= sel_p1_s ? i_p1_din  : i_p0_din;
            stb_r    <= 1'b1;
            active_r <= 1'b1;
            state_r  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Strobe stays up until the controller shows it took the command.
          if (i_m_busy) begin
            stb_r   <= 1'b0;
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!i_m_busy && i_m_done) begin
            ack0_r <= !owner_r;
            ack1_r <= owner_r;
            if (!we_r) begin
              if (owner_r) begin
                rdata1_r <= i_m_dout;
              end else begin
                rdata0_r <= i_m_dout;
              end
            end
            state_r <= ST_ACK;
          end
        end
        ST_ACK: begin
          ack0_r   <= 1'b0;
          ack1_r   <= 1'b0;
          active_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          stb_r    <= 1'b0;
          ack0_r   <= 1'b0;
          ack1_r   <= 1'b0;
          active_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_m_stb    = stb_r;
  assign o_m_we     = we_r;
  assign o_m_addr   = addr_r;
  assign o_m_din    = din_r;
  assign o_owner    = owner_r;
  assign o_active   = active_r;
  assign o_p0_ack   = ack0_r;
  assign o_p1_ack   = ack1_r;
  assign o_p0_rdata = rdata0_r;
  assign o_p1_rdata = rdata1_r;

endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter: a round-robin instance (u_rr) and
// a fixed-priority instance (u_fp), each attached to a behavioural PSRAM
// controller model that shares one small tagged memory.
module tb_psram_arbiter;
  localparam int NI = 2;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  logic        req0 [NI];
  logic        req1 [NI];
  logic        we0 [NI];
  logic        we1 [NI];
  logic [23:0] addr0 [NI];
  logic [23:0] addr1 [NI];
  logic [15:0] din0 [NI];
  logic [15:0] din1 [NI];
  logic        ack0_o [NI];
  logic        ack1_o [NI];
  logic [15:0] rd0_o [NI];
  logic [15:0] rd1_o [NI];
  logic        owner_o [NI];
  logic        active_o [NI];
  logic        stb_o [NI];
  logic        mwe_o [NI];
  logic [23:0] maddr_o [NI];
  logic [15:0] mdin_o [NI];
  logic        m_busy [NI];
  logic        m_done [NI];
  logic [15:0] m_dout [NI];

  psram_arbiter #(.PRIO_MODE(0)) u_rr (
    .i_clk(clk), .arst_n(arst_n),
    .i_p0_req(req0[0]), .i_p1_req(req1[0]), .i_p0_we(we0[0]), .i_p1_we(we1[0]),
    .i_p0_addr(addr0[0]), .i_p1_addr(addr1[0]), .i_p0_din(din0[0]), .i_p1_din(din1[0]),
    .o_p0_ack(ack0_o[0]), .o_p1_ack(ack1_o[0]), .o_p0_rdata(rd0_o[0]), .o_p1_rdata(rd1_o[0]),
    .o_owner(owner_o[0]), .o_active(active_o[0]), .o_m_stb(stb_o[0]), .o_m_we(mwe_o[0]),
    .o_m_addr(maddr_o[0]), .o_m_din(mdin_o[0]),
    .i_m_busy(m_busy[0]), .i_m_done(m_done[0]), .i_m_dout(m_dout[0]));

  psram_arbiter #(.PRIO_MODE(1)) u_fp (
    .i_clk(clk), .arst_n(arst_n),
    .i_p0_req(req0[1]), .i_p1_req(req1[1]), .i_p0_we(we0[1]), .i_p1_we(we1[1]),
    .i_p0_addr(addr0[1]), .i_p1_addr(addr1[1]), .i_p0_din(din0[1]), .i_p1_din(din1[1]),
    .o_p0_ack(ack0_o[1]), .o_p1_ack(ack1_o[1]), .o_p0_rdata(rd0_o[1]), .o_p1_rdata(rd1_o[1]),
    .o_owner(owner_o[1]), .o_active(active_o[1]), .o_m_stb(stb_o[1]), .o_m_we(mwe_o[1]),
    .o_m_addr(maddr_o[1]), .o_m_din(mdin_o[1]),
    .i_m_busy(m_busy[1]), .i_m_done(m_done[1]), .i_m_dout(m_dout[1]));

  // ---------------- PSRAM controller model ----------------
  logic        init_done = 1'b0;
  int          lat_force = 0;
  logic        mem_vld [64] = '{default: 1'b0};
  logic [23:0] mem_tag [64];
  logic [15:0] mem_dat [64];
  int          mstate [NI];
  int          cnt [NI];
  logic [15:0] hold [NI];
  int          strobes [NI] = '{0, 0};
  logic        gowner [NI][16];

  // Contents of a never-written location (0x123456 is pre-seeded).
  function automatic logic [15:0] fill(input logic [23:0] a);
    return (a == 24'h123456) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] mem_rd(input logic [23:0] a);
    if (mem_vld[a[5:0]] && mem_tag[a[5:0]] == a) return mem_dat[a[5:0]];
    return fill(a);
  endfunction

  // Model: not ready until init_done, then accepts a strobe, stays busy a
  // few cycles with garbage on dout, and finishes with done=1.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 0; k < NI; k++) begin
        mstate[k] <= 0;
        m_busy[k] <= 1'b1;
        m_done[k] <= 1'b0;
        m_dout[k] <= 16'h0000;
        cnt[k]    <= 0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        case (mstate[k])
          0: if (init_done) begin
            m_busy[k] <= 1'b0; m_done[k] <= 1'b1; mstate[k] <= 1;
          end
          1: if (stb_o[k]) begin
            m_busy[k] <= 1'b1;
            m_done[k] <= 1'b0;
            m_dout[k] <= 16'($urandom);
            cnt[k]    <= (lat_force > 0) ? lat_force : int'($urandom_range(0, 3));
            mstate[k] <= 2;
            gowner[k][strobes[k] % 16] <= owner_o[k];
            strobes[k] <= strobes[k] + 1;
            if (mwe_o[k]) begin
              mem_vld[maddr_o[k][5:0]] <= 1'b1;
              mem_tag[maddr_o[k][5:0]] <= maddr_o[k];
              mem_dat[maddr_o[k][5:0]] <= mdin_o[k];
              hold[k] <= mdin_o[k];
            end else begin
              hold[k] <= mem_rd(maddr_o[k]);
            end
          end
          default: if (cnt[k] == 0) begin
            m_busy[k] <= 1'b0; m_done[k] <= 1'b1; m_dout[k] <= hold[k]; mstate[k] <= 1;
          end else begin
            cnt[k] <= cnt[k] - 1;
          end
        endcase
      end
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] shadow [logic [23:0]];
  logic [15:0] exp_rd [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ack_of(input int k, input int port);
    return (port != 0) ? ack1_o[k] : ack0_o[k];
  endfunction

  task automatic set_req(input int k, input int port, input logic v);
    if (port != 0) req1[k] = v; else req0[k] = v;
  endtask

  task automatic set_cmd(input int k, input int port, input logic we, input logic [23:0] a, input logic [15:0] d);
    if (port != 0) begin we1[k] = we; addr1[k] = a; din1[k] = d; end
    else begin we0[k] = we; addr0[k] = a; din0[k] = d; end
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin req0[k] = 1'b0; req1[k] = 1'b0; end
    tick(); tick();
    arst_n = 1'b1;
  endtask

  // One transaction on u_rr; reports acks seen and the command on the bus.
  task automatic txn0(input int port, input logic we, input logic [23:0] a, input logic [15:0] d,
                      output int acks, output logic [23:0] caddr, output logic cwe,
                      output logic [15:0] cdin, output logic cown);
    logic got;
    logic prev;
    acks = 0; got = 1'b0; prev = 1'b0;
    caddr = 24'h000000; cwe = 1'b0; cdin = 16'h0000; cown = 1'b0;
    set_cmd(0, port, we, a, d);
    set_req(0, port, 1'b1);
    for (int c = 0; c < 100 && !got; c++) begin
      tick();
      if (stb_o[0] && !prev) begin
        caddr = maddr_o[0]; cwe = mwe_o[0]; cdin = mdin_o[0]; cown = owner_o[0];
      end
      prev = stb_o[0];
      if (ack_of(0, port)) begin got = 1'b1; acks++; set_req(0, port, 1'b0); end
    end
    set_req(0, port, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ack_of(0, port)) acks++;
    end
  endtask

  // Keeps req high until n acks have been received on that port.
  task automatic burst(input int k, input int port, input int n, output int got);
    got = 0;
    set_cmd(k, port, 1'b0, 24'h00A000 + 24'(port), 16'h0000);
    set_req(k, port, 1'b1);
    for (int c = 0; c < 400 && got < n; c++) begin
      tick();
      if (ack_of(k, port)) begin
        got++;
        if (got == n) set_req(k, port, 1'b0);
      end
    end
    set_req(k, port, 1'b0);
  endtask

  // Random requester on u_rr checked against the shadow memory model.
  task automatic rand_port(input int port, input int n);
    logic        w;
    logic [23:0] a;
    logic [15:0] d;
    logic        got;
    for (int t = 0; t < n; t++) begin
      w = 1'($urandom_range(0, 1));
      a = 24'h00A000 + 24'($urandom_range(0, 7));
      d = 16'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      set_cmd(0, port, w, a, d);
      set_req(0, port, 1'b1);
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        tick();
        if (ack_of(0, port)) begin
          got = 1'b1;
          set_req(0, port, 1'b0);
          check("rnd_addr", 32'(maddr_o[0]), 32'(a));
          check("rnd_we", 32'(mwe_o[0]), 32'(w));
          check("rnd_din", 32'(mdin_o[0]), 32'(d));
          check("rnd_owner", 32'(owner_o[0]), 32'(port));
          if (w) shadow[a] = d;
          else exp_rd[port] = shadow.exists(a) ? shadow[a] : fill(a);
          check("rnd_rd0", 32'(rd0_o[0]), 32'(exp_rd[0]));
          check("rnd_rd1", 32'(rd1_o[0]), 32'(exp_rd[1]));
        end
      end
      check("rnd_ack_timeout", 32'(got), 32'd1);
      set_req(0, port, 1'b0);
    end
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [23:0] addr;
    logic [15:0] din;
    logic [15:0] exp_rd0;
    logic [15:0] exp_rd1;
  } vec_t;

  initial begin
    vec_t        vt [8];
    int          acks, g0, g1, base, n;
    logic [23:0] caddr;
    logic        cwe, cown, seen, prev;
    logic [15:0] cdin;

    vt[0] = '{0, 1'b0, 24'h123456, 16'h0000, 16'hBEEF, 16'h0000};
    vt[1] = '{1, 1'b1, 24'h000010, 16'hA5A5, 16'hBEEF, 16'h0000};
    vt[2] = '{1, 1'b0, 24'h000010, 16'h0000, 16'hBEEF, 16'hA5A5};
    vt[3] = '{0, 1'b1, 24'h000020, 16'h1234, 16'hBEEF, 16'hA5A5};
    vt[4] = '{1, 1'b0, 24'h000020, 16'h0000, 16'hBEEF, 16'h1234};
    vt[5] = '{0, 1'b0, 24'h000030, 16'h0000, 16'h5A6A, 16'h1234};
    vt[6] = '{1, 1'b1, 24'hFFFFFF, 16'hFFFF, 16'h5A6A, 16'h1234};
    vt[7] = '{0, 1'b0, 24'hFFFFFF, 16'h0000, 16'hFFFF, 16'h1234};

    arst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      req0[k] = 1'b0; req1[k] = 1'b0; we0[k] = 1'b0; we1[k] = 1'b0;
      addr0[k] = 24'h000000; addr1[k] = 24'h000000; din0[k] = 16'h0000; din1[k] = 16'h0000;
    end
    tick(); tick();

    // Reset values
    check("rst_stb", 32'(stb_o[0]), 32'd0);
    check("rst_we", 32'(mwe_o[0]), 32'd0);
    check("rst_addr", 32'(maddr_o[0]), 32'd0);
    check("rst_din", 32'(mdin_o[0]), 32'd0);
    check("rst_ack0", 32'(ack0_o[0]), 32'd0);
    check("rst_ack1", 32'(ack1_o[0]), 32'd0);
    check("rst_rd0", 32'(rd0_o[0]), 32'd0);
    check("rst_rd1", 32'(rd1_o[0]), 32'd0);
    check("rst_owner", 32'(owner_o[0]), 32'd1);
    check("rst_active", 32'(active_o[0]), 32'd0);
    arst_n = 1'b1;

    // 1. Init gate
    set_cmd(0, 0, 1'b0, 24'h000001, 16'h0000);
    req0[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (stb_o[0]) seen = 1'b1;
    end
    check("init_hold_no_stb", 32'(seen), 32'd0);
    init_done = 1'b1;
    tick();
    check("init_ready_seen_stb_low", 32'(stb_o[0]), 32'd0);
    tick();
    check("init_stb_after_ready", 32'(stb_o[0]), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      tick();
      if (ack0_o[0]) seen = 1'b1;
    end
    req0[0] = 1'b0;
    check("init_ack", 32'(seen), 32'd1);
    check("init_rd0", 32'(rd0_o[0]), 32'(16'h5A5B));

    // 2/5. Table of single transactions
    do_reset();
    for (int i = 0; i < 8; i++) begin
      txn0(vt[i].port, vt[i].we, vt[i].addr, vt[i].din, acks, caddr, cwe, cdin, cown);
      check($sformatf("vec%0d_addr", i), 32'(caddr), 32'(vt[i].addr));
      check($sformatf("vec%0d_we", i), 32'(cwe), 32'(vt[i].we));
      check($sformatf("vec%0d_din", i), 32'(cdin), 32'(vt[i].din));
      check($sformatf("vec%0d_owner", i), 32'(cown), 32'(vt[i].port));
      check($sformatf("vec%0d_acks", i), 32'(acks), 32'd1);
      check($sformatf("vec%0d_rd0", i), 32'(rd0_o[0]), 32'(vt[i].exp_rd0));
      check($sformatf("vec%0d_rd1", i), 32'(rd1_o[0]), 32'(vt[i].exp_rd1));
    end

    // 5. Back-to-back write then read on p1 with req held high
    base = strobes[0];
    n = 0; prev = 1'b0;
    set_cmd(0, 1, 1'b1, 24'h000010, 16'hA5A5);
    req1[0] = 1'b1;
    for (int c = 0; c < 200 && n < 2; c++) begin
      tick();
      if (stb_o[0] && !prev) begin
        if (n == 0) check("b2b_wr_din", 32'(mdin_o[0]), 32'(16'hA5A5));
        check("b2b_we", 32'(mwe_o[0]), (n == 0) ? 32'd1 : 32'd0);
      end
      prev = stb_o[0];
      if (ack1_o[0]) begin
        n++;
        if (n == 1) we1[0] = 1'b0;
        else req1[0] = 1'b0;
      end
    end
    req1[0] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ack1_o[0]) n++;
    end
    check("b2b_acks", 32'(n), 32'd2);
    check("b2b_strobes", 32'(strobes[0] - base), 32'd2);
    check("b2b_rd1", 32'(rd1_o[0]), 32'(16'hA5A5));

    // 3. Round-robin
    do_reset();
    base = strobes[0];
    fork
      burst(0, 0, 4, g0);
      burst(0, 1, 4, g1);
    join
    tick(); tick();
    check("rr_acks_p0", 32'(g0), 32'd4);
    check("rr_acks_p1", 32'(g1), 32'd4);
    check("rr_strobes", 32'(strobes[0] - base), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("rr_grant%0d", i), 32'(gowner[0][(base + i) % 16]), 32'(i % 2));

    // 4. Fixed priority
    do_reset();
    base = strobes[1];
    fork
      burst(1, 0, 4, g0);
      burst(1, 1, 4, g1);
    join
    tick(); tick();
    check("fp_acks_p0", 32'(g0), 32'd4);
    check("fp_acks_p1", 32'(g1), 32'd4);
    check("fp_strobes", 32'(strobes[1] - base), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("fp_grant%0d", i), 32'(gowner[1][(base + i) % 16]), (i < 4) ? 32'd0 : 32'd1);

    // 6. Reset during WAIT of a p0 read
    do_reset();
    lat_force = 8;
    set_cmd(0, 0, 1'b0, 24'h00A003, 16'h0000);
    req0[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (stb_o[0]) seen = 1'b1;
      if (seen && !stb_o[0]) break;
    end
    check("mid_in_wait", {30'd0, stb_o[0], active_o[0]}, 32'd1);
    req0[0] = 1'b0;
    tick();
    arst_n = 1'b0;
    #1;
    check("mid_rst_stb", 32'(stb_o[0]), 32'd0);
    check("mid_rst_addr", 32'(maddr_o[0]), 32'd0);
    check("mid_rst_active", 32'(active_o[0]), 32'd0);
    check("mid_rst_owner", 32'(owner_o[0]), 32'd1);
    check("mid_rst_ack0", 32'(ack0_o[0]), 32'd0);
    check("mid_rst_rd0", 32'(rd0_o[0]), 32'd0);
    tick(); tick();
    arst_n = 1'b1;
    lat_force = 0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (ack0_o[0]) n++;
    end
    check("mid_no_ack", 32'(n), 32'd0);
    txn0(0, 1'b0, 24'h00A004, 16'h0000, acks, caddr, cwe, cdin, cown);
    check("mid_after_acks", 32'(acks), 32'd1);
    check("mid_after_rd0", 32'(rd0_o[0]), 32'(16'hFA5E));

    // Randomized traffic against the shadow memory
    do_reset();
    exp_rd[0] = 16'h0000;
    exp_rd[1] = 16'h0000;
    base = strobes[0];
    fork
      rand_port(0, 30);
      rand_port(1, 30);
    join
    tick(); tick();
    check("rnd_strobes", 32'(strobes[0] - base), 32'd60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
